// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid.
// Stall (EN_), flush (CLR) and saturating stall statistics.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             RST_,
  input  logic             EN_,
  input  logic             CLR,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_v;
  logic             skid_v;
  logic             in_fire;
  logic             out_fire;
  logic             st_empty;
  logic             st_one;
  logic             st_full;

  // ready depends only on registered state and EN_
  assign in_ready  = ~skid_v & ~EN_;
  assign out_valid = main_v & ~EN_;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  assign st_empty = ~main_v;
  assign st_one   = main_v & ~skid_v;
  assign st_full  = main_v & skid_v;

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (CLR) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= CLR_VALUE;
      skid_data <= CLR_VALUE;
    end else begin
      unique case (1'b1)
        st_empty: begin
          if (in_fire) begin
            main_v    <= 1'b1;
            main_data <= in_data;
          end
        end
        st_one: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_v    <= 1'b1;
            skid_data <= in_data;
          end else if (out_fire) begin
            main_v <= 1'b0;
          end
        end
        st_full: begin
          if (out_fire) begin
            skid_v    <= 1'b0;
            main_data <= skid_data;
          end
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  // counts held-but-not-emitted cycles, flush does not touch it
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      stall_cnt <= '0;
    end else if (main_v && !out_fire && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed phases plus random traffic
// against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned      W    = 32;
  localparam int unsigned      CW   = 4;
  localparam logic [W-1:0]     CLRV = 32'hDEAD_BEEF;

  logic          clk;
  logic          RST_;
  logic          EN_;
  logic          CLR;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_skid_reg #(
    .WIDTH    (W),
    .CLR_VALUE(CLRV),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .RST_     (RST_),
    .EN_      (EN_),
    .CLR      (CLR),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vectors;
  int           miscompares;
  logic [W-1:0] q[$];
  logic [W-1:0] stale;
  int           cnt;
  int           emitted_3;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    stale = '0;
    cnt   = 0;
  endtask

  task automatic check_all();
    logic [W-1:0] head;
    head = (q.size() > 0) ? q[0] : stale;
    chk("in_ready", W'(in_ready), W'((q.size() < 2) && !EN_));
    chk("out_valid", W'(out_valid), W'((q.size() > 0) && !EN_));
    chk("out_data", out_data, head);
    chk("occupancy", W'(occupancy), W'(q.size()));
    chk("stall_cnt", W'(stall_cnt), W'(cnt));
  endtask

  // drive one cycle, check, advance model, pass the edge
  task automatic cycle(input logic en_n, input logic clr,
                       input logic iv, input logic [W-1:0] id,
                       input logic ordy);
    logic rdy;
    logic ov;
    logic ifire;
    logic ofire;
    EN_       = en_n;
    CLR       = clr;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check_all();
    rdy   = (q.size() < 2) && !en_n;
    ov    = (q.size() > 0) && !en_n;
    ifire = iv && rdy;
    ofire = ov && ordy;
    if (ofire && q[0] == 32'h3) emitted_3++;
    if ((q.size() > 0) && !ofire && cnt < (2**CW - 1)) cnt++;
    if (ofire) stale = q.pop_front();
    if (clr) begin
      q.delete();
      stale = CLRV;
    end else if (ifire) begin
      q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    emitted_3   = 0;
    RST_      = 1'b0;
    EN_       = 1'b0;
    CLR       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_all();
    #10;
    RST_ = 1'b1;
    @(posedge clk);
    #1;

    // streaming
    for (int i = 1; i <= 6; i++) cycle(0, 0, 1, W'(i), 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);

    // back-pressure
    cycle(0, 0, 1, 32'hA, 0);
    cycle(0, 0, 1, 32'hB, 0);
    cycle(0, 0, 1, 32'h99, 0);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);

    // stall
    cycle(0, 0, 1, 32'hC, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 32'h77, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);

    // flush from FULL while stalled, younger 0x3 killed
    emitted_3 = 0;
    cycle(0, 0, 1, 32'h1, 0);
    cycle(0, 0, 1, 32'h2, 0);
    cycle(1, 1, 1, 32'h3, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);
    chk("no_0x3", W'(emitted_3), '0);

    // saturation
    cycle(0, 0, 1, 32'h55, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, 0);
    chk("sat", W'(stall_cnt), 32'hF);
    cycle(0, 0, 0, '0, 1);

    // async reset while FULL, between edges
    cycle(0, 0, 1, 32'h11, 0);
    cycle(0, 0, 1, 32'h22, 0);
    in_valid = 1'b0;
    #2;
    RST_ = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    RST_ = 1'b1;
    cycle(0, 0, 1, 32'h33, 1);
    cycle(0, 0, 0, '0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
